// File: rtl/move_piece_grid_if.sv
// Handshake and status bundle between the piece mover and its neighbours.
// The debouncer side drives the step/move requests; the display side reads the board.
interface move_piece_grid_if #(
    parameter int COLS   = 4,
    parameter int ROWS   = 8,
    parameter int LINE_W = 8
);
    logic                      step;
    logic                      left;
    logic                      right;
    logic                      rotate;
    logic [1:0]                next_type;
    logic [COLS*ROWS-1:0]      board;
    logic [$clog2(ROWS)-1:0]   piece_row;
    logic [$clog2(COLS)-1:0]   piece_col;
    logic [1:0]                piece_rot;
    logic                      busy;
    logic                      done;
    logic                      touched;
    logic [LINE_W-1:0]         lines;
    logic                      game_over;

    modport master (
        output step, left, right, rotate, next_type,
        input  board, piece_row, piece_col, piece_rot,
        input  busy, done, touched, lines, game_over
    );

    modport slave (
        input  step, left, right, rotate, next_type,
        output board, piece_row, piece_col, piece_rot,
        output busy, done, touched, lines, game_over
    );
endinterface

// File: rtl/move_piece_grid.sv
// Falling-piece playfield: one user move plus one gravity drop per step,
// with locking, row clearing, respawn and game-over detection.
module move_piece_grid #(
    parameter int COLS      = 4,
    parameter int ROWS      = 8,
    parameter int SPAWN_COL = 1,
    parameter int LINE_W    = 8
) (
    input  logic             clka,
    input  logic             restart,
    move_piece_grid_if.slave bus
);
    localparam int N  = COLS * ROWS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        FALL,
        CLEAR,
        SPAWN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MV_NONE,
        MV_LEFT,
        MV_RIGHT,
        MV_ROT
    } move_t;

    state_t            state;
    state_t            state_nx;
    move_t             mv;
    logic [N-1:0]      locked;
    logic [1:0]        p_type;
    logic [1:0]        p_rot;
    logic [RW-1:0]     p_row;
    logic [CW-1:0]     p_col;
    logic [RW-1:0]     scan_r;
    logic              touched_r;
    logic              done_r;
    logic              game_over_r;
    logic [LINE_W-1:0] lines_r;

    logic [1:0]        cand_type;
    logic [1:0]        cand_rot;
    logic [RW:0]       cand_row;
    logic [CW:0]       cand_col;
    logic [N:0]        cand_p;
    logic [N:0]        cur_p;
    logic              cand_ok;
    logic              row_full;
    logic [N-1:0]      row_mask;
    logic [N-1:0]      below_mask;
    logic [N-1:0]      above_mask;
    logic [N-1:0]      cleared;
    logic              show;

    // Occupied cells of the 2x2 box as m3..m0.
    function automatic logic [3:0] shape(input logic [1:0] t, input logic [1:0] r);
        case (t)
            2'd0:    shape = 4'b0001;
            2'd1:    shape = r[0] ? 4'b0011 : 4'b0101;
            2'd2:    shape = 4'b1111;
            default: begin
                case (r)
                    2'd0:    shape = 4'b1101;
                    2'd1:    shape = 4'b0111;
                    2'd2:    shape = 4'b1011;
                    default: shape = 4'b1110;
                endcase
            end
        endcase
    endfunction

    // Returns {out_of_bounds, cell mask}; coordinates carry spare bits so nothing wraps.
    function automatic logic [N:0] place(input logic [1:0] t, input logic [1:0] r,
                                         input logic [RW:0] prow, input logic [CW:0] pcol);
        logic [3:0]    m;
        logic [RW+1:0] cr;
        logic [CW+1:0] cc;
        logic [N-1:0]  cells;
        logic          oob;
        m     = shape(t, r);
        cells = '0;
        oob   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cr = {1'b0, prow} + (RW+2)'(i / 2);
            cc = {1'b0, pcol} + (CW+2)'(i % 2);
            if (m[i]) begin
                if (int'(cr) >= ROWS || int'(cc) >= COLS) begin
                    oob = 1'b1;
                end else begin
                    cells = cells | (N'(1) << (int'(cr) * COLS + int'(cc)));
                end
            end
        end
        place = {oob, cells};
    endfunction

    always_comb begin
        cand_type = p_type;
        cand_rot  = p_rot;
        cand_row  = {1'b0, p_row};
        cand_col  = {1'b0, p_col};
        case (state)
            SHIFT: begin
                case (mv)
                    MV_LEFT:  cand_col = {1'b0, p_col} - (CW+1)'(1);
                    MV_RIGHT: cand_col = {1'b0, p_col} + (CW+1)'(1);
                    MV_ROT:   cand_rot = p_rot + 2'd1;
                    default:  ;
                endcase
            end
            FALL:  cand_row = {1'b0, p_row} + (RW+1)'(1);
            SPAWN: begin
                cand_type = bus.next_type;
                cand_rot  = 2'd0;
                cand_row  = '0;
                cand_col  = (CW+1)'(SPAWN_COL);
            end
            default: ;
        endcase
        cand_p  = place(cand_type, cand_rot, cand_row, cand_col);
        cand_ok = !cand_p[N] && ((cand_p[N-1:0] & locked) == '0);
    end

    // Row-clear helpers for the row under scan; rows above it slide down by one.
    always_comb begin
        cur_p      = place(p_type, p_rot, {1'b0, p_row}, {1'b0, p_col});
        row_mask   = {{(N-COLS){1'b0}}, {COLS{1'b1}}} << (int'(scan_r) * COLS);
        below_mask = ~({N{1'b1}} << (int'(scan_r) * COLS));
        above_mask = {N{1'b1}} << ((int'(scan_r) + 1) * COLS);
        row_full   = (locked & row_mask) == row_mask;
        cleared    = (locked & above_mask) | ((locked & below_mask) << COLS);
        show       = !game_over_r && !cur_p[N] && (state != CLEAR) && (state != SPAWN);
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.step && !game_over_r) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: state_nx = FALL;
            FALL:  state_nx = cand_ok ? DONE : CLEAR;
            CLEAR: begin
                if (!row_full && scan_r == '0) begin
                    state_nx = SPAWN;
                end
            end
            SPAWN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            locked      <= '0;
            p_type      <= 2'd0;
            p_row       <= '0;
            p_col       <= CW'(SPAWN_COL);
            p_rot       <= 2'd0;
            mv          <= MV_NONE;
            scan_r      <= '0;
            touched_r   <= 1'b0;
            done_r      <= 1'b0;
            lines_r     <= '0;
            game_over_r <= 1'b0;
        end else begin
            done_r <= (state == DONE);
            case (state)
                IDLE: begin
                    if (bus.step && !game_over_r) begin
                        if (bus.left) begin
                            mv <= MV_LEFT;
                        end else if (bus.right) begin
                            mv <= MV_RIGHT;
                        end else if (bus.rotate) begin
                            mv <= MV_ROT;
                        end else begin
                            mv <= MV_NONE;
                        end
                    end
                end
                SHIFT: begin
                    if (cand_ok) begin
                        p_col <= cand_col[CW-1:0];
                        p_rot <= cand_rot;
                    end
                end
                FALL: begin
                    if (cand_ok) begin
                        p_row     <= cand_row[RW-1:0];
                        touched_r <= 1'b0;
                    end else begin
                        locked    <= locked | cur_p[N-1:0];
                        touched_r <= 1'b1;
                        scan_r    <= RW'(ROWS - 1);
                    end
                end
                CLEAR: begin
                    if (row_full) begin
                        locked <= cleared;
                        if (lines_r != {LINE_W{1'b1}}) begin
                            lines_r <= lines_r + LINE_W'(1);
                        end
                    end else if (scan_r != '0) begin
                        scan_r <= scan_r - RW'(1);
                    end
                end
                SPAWN: begin
                    p_type <= bus.next_type;
                    p_row  <= '0;
                    p_col  <= CW'(SPAWN_COL);
                    p_rot  <= 2'd0;
                    if (!cand_ok) begin
                        game_over_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.board     = locked | (show ? cur_p[N-1:0] : '0);
    assign bus.piece_row = p_row;
    assign bus.piece_col = p_col;
    assign bus.piece_rot = p_rot;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_r;
    assign bus.touched   = touched_r;
    assign bus.lines     = lines_r;
    assign bus.game_over = game_over_r;
endmodule

// File: tb/tb_move_piece_grid.sv
// Directed bench for move_piece_grid: a table of steps through one game,
// then hand-written sequences for dropped steps, game over and restart mid-clear.
module tb_move_piece_grid;
    localparam int COLS      = 4;
    localparam int ROWS      = 8;
    localparam int SPAWN_COL = 1;
    localparam int LINE_W    = 8;
    localparam int NV        = 31;

    logic clka    = 1'b0;
    logic restart = 1'b1;

    always #5 clka = ~clka;

    move_piece_grid_if #(.COLS(COLS), .ROWS(ROWS), .LINE_W(LINE_W)) bus ();

    move_piece_grid #(
        .COLS(COLS), .ROWS(ROWS), .SPAWN_COL(SPAWN_COL), .LINE_W(LINE_W)
    ) dut (
        .clka(clka),
        .restart(restart),
        .bus(bus)
    );

    typedef struct {
        logic        l;
        logic        r;
        logic        ro;
        logic [1:0]  nt;
        int          cyc;
        logic        tch;
        logic [31:0] brd;
        int          row;
        int          col;
        int          rot;
        int          lines;
    } vec_t;

    vec_t vecs [NV];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_step(input logic l, input logic r, input logic ro, input logic [1:0] nt,
                           output int cyc, output bit got);
        bus.left      = l;
        bus.right     = r;
        bus.rotate    = ro;
        bus.next_type = nt;
        bus.step      = 1'b1;
        @(posedge clka);
        #1;
        bus.step   = 1'b0;
        bus.left   = 1'b0;
        bus.right  = 1'b0;
        bus.rotate = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clka);
            cyc++;
            @(negedge clka);
            if (bus.done) got = 1'b1;
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".board"},   64'(bus.board), 64'h2);
        chk({tag, ".row"},     64'(bus.piece_row), 64'd0);
        chk({tag, ".col"},     64'(bus.piece_col), 64'(SPAWN_COL));
        chk({tag, ".rot"},     64'(bus.piece_rot), 64'd0);
        chk({tag, ".busy"},    64'(bus.busy), 64'd0);
        chk({tag, ".done"},    64'(bus.done), 64'd0);
        chk({tag, ".touched"}, 64'(bus.touched), 64'd0);
        chk({tag, ".lines"},   64'(bus.lines), 64'd0);
        chk({tag, ".go"},      64'(bus.game_over), 64'd0);
    endtask

    initial begin
        int  cyc;
        bit  got;
        int  steps;
        bit  seen;

        //          l     r     ro    nt    cyc tch   board          row col rot lines
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 3,  1'b0, 32'h0000_0020, 1, 1, 0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 3,  1'b0, 32'h0000_0100, 2, 0, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 3,  1'b0, 32'h0000_1000, 3, 0, 0, 0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'd0, 3,  1'b0, 32'h0001_0000, 4, 0, 0, 0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 3,  1'b0, 32'h0020_0000, 5, 1, 0, 0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'd0, 3,  1'b0, 32'h0400_0000, 6, 2, 0, 0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'd0, 3,  1'b0, 32'h4000_0000, 7, 2, 1, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'd2, 12, 1'b1, 32'h4000_0066, 0, 1, 0, 0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 3,  1'b0, 32'h4000_0330, 1, 0, 0, 0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 3,  1'b0, 32'h4000_3300, 2, 0, 0, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 3,  1'b0, 32'h4003_3000, 3, 0, 0, 0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 3,  1'b0, 32'h4033_0000, 4, 0, 0, 0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 3,  1'b0, 32'h4330_0000, 5, 0, 0, 0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 2'd0, 3,  1'b0, 32'h7300_0000, 6, 0, 0, 0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 2'd0, 12, 1'b1, 32'h7300_0002, 0, 1, 0, 0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 2'd0, 3,  1'b0, 32'h7300_0040, 1, 2, 0, 0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 2'd0, 3,  1'b0, 32'h7300_0800, 2, 3, 0, 0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 2'd0, 3,  1'b0, 32'h7300_8000, 3, 3, 0, 0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 2'd0, 3,  1'b0, 32'h7308_0000, 4, 3, 0, 0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 2'd0, 3,  1'b0, 32'h7380_0000, 5, 3, 0, 0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 2'd0, 3,  1'b0, 32'h7B00_0000, 6, 3, 0, 0};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 2'd0, 3,  1'b0, 32'hF300_0000, 7, 3, 0, 0};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 2'd1, 13, 1'b1, 32'h3000_0022, 0, 1, 0, 1};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 2'd0, 3,  1'b0, 32'h3000_0440, 1, 2, 0, 1};
        vecs[24] = '{1'b0, 1'b1, 1'b0, 2'd0, 3,  1'b0, 32'h3000_8800, 2, 3, 0, 1};
        vecs[25] = '{1'b0, 1'b0, 1'b1, 2'd0, 3,  1'b0, 32'h3008_8000, 3, 3, 0, 1};
        vecs[26] = '{1'b1, 1'b0, 1'b0, 2'd0, 3,  1'b0, 32'h3044_0000, 4, 2, 0, 1};
        vecs[27] = '{1'b0, 1'b0, 1'b1, 2'd0, 3,  1'b0, 32'h30C0_0000, 5, 2, 1, 1};
        vecs[28] = '{1'b0, 1'b0, 1'b0, 2'd0, 3,  1'b0, 32'h3C00_0000, 6, 2, 1, 1};
        vecs[29] = '{1'b0, 1'b0, 1'b0, 2'd0, 3,  1'b0, 32'hF000_0000, 7, 2, 1, 1};
        vecs[30] = '{1'b0, 1'b0, 1'b0, 2'd0, 13, 1'b1, 32'h0000_0002, 0, 1, 0, 2};

        bus.step      = 1'b0;
        bus.left      = 1'b0;
        bus.right     = 1'b0;
        bus.rotate    = 1'b0;
        bus.next_type = 2'd0;

        repeat (2) @(posedge clka);
        #1 restart = 1'b0;
        @(negedge clka);
        chk_reset_values("reset");

        for (int i = 0; i < NV; i++) begin
            do_step(vecs[i].l, vecs[i].r, vecs[i].ro, vecs[i].nt, cyc, got);
            chk($sformatf("v%0d.done_seen", i), 64'(got), 64'd1);
            chk($sformatf("v%0d.cycles", i),  64'(cyc), 64'(vecs[i].cyc));
            chk($sformatf("v%0d.touched", i), 64'(bus.touched), 64'(vecs[i].tch));
            chk($sformatf("v%0d.board", i),   64'(bus.board), 64'(vecs[i].brd));
            chk($sformatf("v%0d.row", i),     64'(bus.piece_row), 64'(vecs[i].row));
            chk($sformatf("v%0d.col", i),     64'(bus.piece_col), 64'(vecs[i].col));
            chk($sformatf("v%0d.rot", i),     64'(bus.piece_rot), 64'(vecs[i].rot));
            chk($sformatf("v%0d.lines", i),   64'(bus.lines), 64'(vecs[i].lines));
            chk($sformatf("v%0d.go", i),      64'(bus.game_over), 64'd0);
        end

        // Step held high while busy must not queue a second move.
        bus.step = 1'b1;
        @(posedge clka);
        #1;
        chk("drop.busy_at_accept", 64'(bus.busy), 64'd1);
        @(posedge clka);
        @(posedge clka);
        #1 bus.step = 1'b0;
        @(posedge clka);
        @(negedge clka);
        chk("drop.done", 64'(bus.done), 64'd1);
        @(posedge clka);
        @(negedge clka);
        chk("drop.busy_after", 64'(bus.busy), 64'd0);
        chk("drop.done_after", 64'(bus.done), 64'd0);
        chk("drop.row", 64'(bus.piece_row), 64'd1);

        // Stack singles in column 1 until the spawn collides.
        steps = 0;
        while (!bus.game_over && steps < 60) begin
            do_step(1'b0, 1'b0, 1'b0, 2'd0, cyc, got);
            steps++;
            if (!got) begin
                chk("go.step_done", 64'd0, 64'd1);
                break;
            end
        end
        chk("go.steps", 64'(steps), 64'd35);
        chk("go.flag", 64'(bus.game_over), 64'd1);
        chk("go.board", 64'(bus.board), 64'h2222_2222);
        chk("go.lines", 64'(bus.lines), 64'd2);

        bus.step = 1'b1;
        @(posedge clka);
        #1 bus.step = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clka);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        chk("go.step_ignored", 64'(seen), 64'd0);

        restart = 1'b1;
        @(posedge clka);
        #1 restart = 1'b0;
        @(negedge clka);
        chk_reset_values("go_restart");

        // Drop a single to the floor, then restart two cycles into CLEAR.
        for (int i = 0; i < 7; i++) begin
            do_step(1'b0, 1'b0, 1'b0, 2'd0, cyc, got);
            if (!got) chk($sformatf("mid.pre%0d_done", i), 64'd0, 64'd1);
        end
        chk("mid.pre_row", 64'(bus.piece_row), 64'd7);
        bus.step = 1'b1;
        @(posedge clka);
        #1 bus.step = 1'b0;
        @(posedge clka);
        @(posedge clka);
        @(posedge clka);
        #1;
        chk("mid.busy_in_clear", 64'(bus.busy), 64'd1);
        chk("mid.board_in_clear", 64'(bus.board), 64'h2000_0000);
        restart = 1'b1;
        @(posedge clka);
        #1 restart = 1'b0;
        @(negedge clka);
        chk_reset_values("mid_restart");
        seen = 1'b0;
        repeat (20) begin
            @(negedge clka);
            if (bus.done) seen = 1'b1;
        end
        chk("mid.no_done", 64'(seen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
